// File: rtl/mem_bus_ram.sv
// Single-port word RAM behind a valid/ready memory bus with optional wait
// states and a sticky out-of-range error capture.
module mem_bus_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err,
  output logic [31:0] err_addr,
  output logic        err_instr,
  input  logic        err_clr
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_instr;
  logic        r_acc_oor;
  logic [31:0] r_ram_q;
  logic [31:0] r_mem [MEM_WORDS];

  logic        w_live;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_wstrb;
  logic        w_acc_instr;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic [AW-1:0] w_idx;
  logic        w_acc_en;

  // With no wait states the RAM is accessed on the acceptance edge itself,
  // so the live bus fields are used; otherwise the captured copies are.
  assign w_live      = (r_state == IDLE);
  assign w_acc_addr  = w_live ? mem_addr  : r_addr;
  assign w_acc_wdata = w_live ? mem_wdata : r_wdata;
  assign w_acc_wstrb = w_live ? mem_wstrb : r_wstrb;
  assign w_acc_instr = w_live ? mem_instr : r_instr;

  // Unsigned wrap makes addresses below BASE_ADDR fail the same compare.
  assign w_offset   = w_acc_addr - BASE_ADDR;
  assign w_in_range = (w_offset < SPAN);
  assign w_idx      = w_offset[AW+1:2];

  // The access edge is the edge that enters RESP; gating with resetn keeps a
  // held reset from committing a write on the bus.
  assign w_acc_en = resetn &&
                    (((r_state == IDLE) && mem_valid && (WS == 4'd0)) ||
                     ((r_state == WAIT) && (r_wait_cnt == 4'd1)));

  // NOTE: non-blocking assignments throughout sequential blocks so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_instr    <= 1'b0;
      r_acc_oor  <= 1'b0;
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'd0;
      err        <= 1'b0;
      err_addr   <= 32'd0;
      err_instr  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_valid) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
            if (WS == 4'd0) begin
              r_state <= RESP;
            end else begin
              r_state    <= WAIT;
              r_wait_cnt <= WS;
            end
          end
        end
        WAIT: begin
          if (r_wait_cnt == 4'd1) begin
            r_state    <= RESP;
            r_wait_cnt <= 4'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        RESP: begin
          mem_ready <= 1'b1;
          mem_rdata <= r_acc_oor ? 32'd0 : r_ram_q;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_acc_en) r_acc_oor <= !w_in_range;

      // A new error on the same edge as err_clr takes priority.
      if (w_acc_en && !w_in_range) begin
        err       <= 1'b1;
        err_addr  <= w_acc_addr;
        err_instr <= w_acc_instr;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // NOTE: the array and its read register carry no reset so the block maps
  // onto block RAM; contents survive resetn.
  always_ff @(posedge clk) begin
    if (w_acc_en && w_in_range) begin
      r_ram_q <= r_mem[w_idx];
      for (int b = 0; b < 4; b++) begin
        if (w_acc_wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
      end
    end
  end

endmodule
